// File: rtl/renkon_bias_fetch_pkg.sv
// Shared renkon definitions: default data/address/count widths and the bias fetch FSM encoding.
package renkon_bias_fetch_pkg;

    localparam int RENKON_DWIDTH = 16;
    localparam int RENKON_BWIDTH = 10;
    localparam int RENKON_NWIDTH = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_LOAD  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_DONE  = 3'd5
    } fetch_state_e;

endpackage

// File: rtl/renkon_bias_fetch_if.sv
// Request, bias memory and bias register signals of the renkon bias fetcher.
interface renkon_bias_fetch_if
    import renkon_bias_fetch_pkg::*;
#(
    parameter int DWIDTH = RENKON_DWIDTH,
    parameter int BWIDTH = RENKON_BWIDTH,
    parameter int NWIDTH = RENKON_NWIDTH
);

    logic                     req;
    logic [BWIDTH-1:0]        base_addr;
    logic [NWIDTH-1:0]        n_out;
    logic                     next;
    logic                     clear;
    logic                     mem_re;
    logic [BWIDTH-1:0]        mem_addr;
    logic [DWIDTH-1:0]        mem_rdata;
    logic                     breg_we;
    logic signed [DWIDTH-1:0] read_bias;
    logic                     busy;
    logic                     done;

    // master is the controller/memory side, slave is the fetcher itself
    modport master (
        output req, base_addr, n_out, next, clear, mem_rdata,
        input  mem_re, mem_addr, breg_we, read_bias, busy, done
    );

    modport slave (
        input  req, base_addr, n_out, next, clear, mem_rdata,
        output mem_re, mem_addr, breg_we, read_bias, busy, done
    );

endinterface

// File: rtl/renkon_bias_fetch.sv
// Fetches n_out consecutive biases from bias memory, presenting each one to the bias-add stage
// and holding it until the consumer asks for the next.
module renkon_bias_fetch
    import renkon_bias_fetch_pkg::*;
#(
    parameter int DWIDTH = RENKON_DWIDTH,
    parameter int BWIDTH = RENKON_BWIDTH,
    parameter int NWIDTH = RENKON_NWIDTH
) (
    input  logic               clk,
    input  logic               xrst,
    renkon_bias_fetch_if.slave bus
);

    fetch_state_e             state_q, state_d;
    logic [BWIDTH-1:0]        base_q;
    logic [NWIDTH-1:0]        count_q;
    logic [NWIDTH-1:0]        index_q;
    logic signed [DWIDTH-1:0] readBias_q;
    logic                     lastBias;

    assign lastBias = (index_q == count_q - NWIDTH'(1));

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // clear wins over everything, so a pending req or next is simply dropped
    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req) begin
                        state_d = (bus.n_out != '0) ? ST_FETCH : ST_DONE;
                    end
                end
                ST_FETCH: state_d = ST_WAIT;
                ST_WAIT:  state_d = ST_LOAD;
                ST_LOAD:  state_d = ST_HOLD;
                ST_HOLD: begin
                    if (bus.next) begin
                        state_d = lastBias ? ST_DONE : ST_FETCH;
                    end
                end
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            base_q     <= '0;
            count_q    <= '0;
            index_q    <= '0;
            readBias_q <= '0;
        end else if (!bus.clear) begin
            if (state_q == ST_IDLE && bus.req && bus.n_out != '0) begin
                base_q  <= bus.base_addr;
                count_q <= bus.n_out;
                index_q <= '0;
            end
            if (state_q == ST_HOLD && bus.next && !lastBias) begin
                index_q <= index_q + NWIDTH'(1);
            end
            // memory data is only valid in the cycle after the read strobe
            if (state_q == ST_WAIT) begin
                readBias_q <= bus.mem_rdata;
            end
        end
    end

    always_comb begin
        bus.mem_re    = (state_q == ST_FETCH);
        bus.mem_addr  = base_q + BWIDTH'(index_q);
        bus.breg_we   = (state_q == ST_LOAD);
        bus.read_bias = readBias_q;
        bus.busy      = (state_q != ST_IDLE);
        bus.done      = (state_q == ST_DONE);
    end

endmodule
